// File: rtl/ssd1306_pkg.sv
// rtl/ssd1306_pkg.sv - SSD1306 opcodes, argument-count sets, address modes and parser states
package ssd1306_pkg;

  localparam int NUM_COLS_DEF  = 128;
  localparam int NUM_PAGES_DEF = 8;

  localparam logic [7:0] OP_ADDR_MODE   = 8'h20;
  localparam logic [7:0] OP_COL_ADDR    = 8'h21;
  localparam logic [7:0] OP_PAGE_ADDR   = 8'h22;
  localparam logic [7:0] OP_CONTRAST    = 8'h81;
  localparam logic [7:0] OP_NORMAL      = 8'hA6;
  localparam logic [7:0] OP_INVERSE     = 8'hA7;
  localparam logic [7:0] OP_DISPLAY_OFF = 8'hAE;
  localparam logic [7:0] OP_DISPLAY_ON  = 8'hAF;

  localparam logic [1:0] AM_HORIZ = 2'b00;
  localparam logic [1:0] AM_VERT  = 2'b01;
  localparam logic [1:0] AM_PAGE  = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_ARG1, ST_ARG2} parse_state_t;

  function automatic logic is_one_arg(input logic [7:0] op);
    case (op)
      8'h81, 8'h20, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDB, 8'h8D: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_two_arg(input logic [7:0] op);
    return (op == OP_COL_ADDR) || (op == OP_PAGE_ADDR);
  endfunction

  // B0..B7 set the page start in page addressing mode
  function automatic logic is_page_select(input logic [7:0] op);
    return op[7:3] == 5'b10110;
  endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// rtl/spi_byte_rx.sv - oversampling SPI byte receiver: synchronisers, sclk edge detect, shift register
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       io_sclk,
  input  logic       io_sdin,
  input  logic       io_cs,
  input  logic       io_dc,
  input  logic       io_reset,
  output logic [7:0] rx_byte,
  output logic       rx_dc,
  output logic       byte_valid,
  output logic       panel_rst_n
);

  logic [SYNC_STAGES-1:0] sclk_q, sdin_q, cs_q, dc_q, rstn_q;
  logic       sclk_s, sdin_s, cs_s, dc_s;
  logic       sclk_prev;
  logic       sclk_rise;
  logic [6:0] shreg;
  logic [2:0] bit_cnt;

  // Chains reset to the idle pin levels so no spurious edge follows rst
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= '1;
      sdin_q <= '0;
      cs_q   <= '1;
      dc_q   <= '0;
      rstn_q <= '1;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], io_sclk};
      sdin_q <= {sdin_q[SYNC_STAGES-2:0], io_sdin};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], io_cs};
      dc_q   <= {dc_q[SYNC_STAGES-2:0], io_dc};
      rstn_q <= {rstn_q[SYNC_STAGES-2:0], io_reset};
    end
  end

  assign sclk_s      = sclk_q[SYNC_STAGES-1];
  assign sdin_s      = sdin_q[SYNC_STAGES-1];
  assign cs_s        = cs_q[SYNC_STAGES-1];
  assign dc_s        = dc_q[SYNC_STAGES-1];
  assign panel_rst_n = rstn_q[SYNC_STAGES-1];
  assign sclk_rise   = sclk_s & ~sclk_prev;

  always_ff @(posedge clk) begin
    if (rst || !panel_rst_n) begin
      sclk_prev  <= 1'b1;
      shreg      <= '0;
      bit_cnt    <= '0;
      byte_valid <= 1'b0;
      rx_byte    <= '0;
      rx_dc      <= 1'b0;
    end else begin
      sclk_prev  <= sclk_s;
      byte_valid <= 1'b0;
      if (cs_s) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        shreg   <= {shreg[5:0], sdin_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          rx_byte    <= {shreg, sdin_s};
          rx_dc      <= dc_s;
        end
      end
    end
  end

endmodule

// File: rtl/ssd1306_spi_sink.sv
// rtl/ssd1306_spi_sink.sv - SSD1306 SPI sink: command parser, register effects, GDDRAM address generator
module ssd1306_spi_sink
  import ssd1306_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_COLS    = NUM_COLS_DEF,
  parameter int NUM_PAGES   = NUM_PAGES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       io_sclk,
  input  logic       io_sdin,
  input  logic       io_cs,
  input  logic       io_dc,
  input  logic       io_reset,
  output logic       cmd_valid,
  output logic [7:0] cmd_opcode,
  output logic [7:0] cmd_arg0,
  output logic [7:0] cmd_arg1,
  output logic       cmd_err,
  output logic       ram_we,
  output logic [9:0] ram_addr,
  output logic [7:0] ram_wdata,
  output logic       frame_done,
  output logic       display_on,
  output logic [7:0] contrast,
  output logic       inverse,
  output logic [1:0] addr_mode
);

  localparam int CW = $clog2(NUM_COLS);
  localparam int PW = $clog2(NUM_PAGES);

  logic [7:0]   rx_byte;
  logic         rx_dc, byte_valid, panel_rst_n, srst;
  parse_state_t state, state_d;
  logic [7:0]   pend_op, pend_a0;
  logic         fire, err, wr;
  logic [7:0]   fire_op, fire_a0, fire_a1;
  logic [CW-1:0] col, col_start, col_end;
  logic [PW-1:0] page, page_start, page_end;

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .io_sclk    (io_sclk),
    .io_sdin    (io_sdin),
    .io_cs      (io_cs),
    .io_dc      (io_dc),
    .io_reset   (io_reset),
    .rx_byte    (rx_byte),
    .rx_dc      (rx_dc),
    .byte_valid (byte_valid),
    .panel_rst_n(panel_rst_n)
  );

  assign srst = rst | ~panel_rst_n;

  always_ff @(posedge clk) begin
    if (srst) state <= ST_IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    fire    = 1'b0;
    fire_op = pend_op;
    fire_a0 = 8'h00;
    fire_a1 = 8'h00;
    err     = 1'b0;
    wr      = 1'b0;
    if (byte_valid) begin
      if (rx_dc) begin
        // A data byte aborts a pending command and is still written
        wr = 1'b1;
        if (state != ST_IDLE) begin
          err     = 1'b1;
          state_d = ST_IDLE;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (is_one_arg(rx_byte) || is_two_arg(rx_byte)) begin
              state_d = ST_ARG1;
            end else begin
              fire    = 1'b1;
              fire_op = rx_byte;
            end
          end
          ST_ARG1: begin
            if (is_two_arg(pend_op)) begin
              state_d = ST_ARG2;
            end else begin
              fire    = 1'b1;
              fire_a0 = rx_byte;
              state_d = ST_IDLE;
            end
          end
          ST_ARG2: begin
            fire    = 1'b1;
            fire_a0 = pend_a0;
            fire_a1 = rx_byte;
            state_d = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      pend_op    <= '0;
      pend_a0    <= '0;
      cmd_valid  <= 1'b0;
      cmd_err    <= 1'b0;
      ram_we     <= 1'b0;
      frame_done <= 1'b0;
      cmd_opcode <= '0;
      cmd_arg0   <= '0;
      cmd_arg1   <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      display_on <= 1'b0;
      contrast   <= 8'h7F;
      inverse    <= 1'b0;
      addr_mode  <= AM_PAGE;
      col_start  <= '0;
      col_end    <= CW'(NUM_COLS - 1);
      page_start <= '0;
      page_end   <= PW'(NUM_PAGES - 1);
      col        <= '0;
      page       <= '0;
    end else begin
      cmd_valid  <= fire;
      cmd_err    <= err;
      ram_we     <= wr;
      frame_done <= 1'b0;
      if (byte_valid && !rx_dc && state == ST_IDLE) pend_op <= rx_byte;
      if (byte_valid && !rx_dc && state == ST_ARG1) pend_a0 <= rx_byte;
      if (fire) begin
        cmd_opcode <= fire_op;
        cmd_arg0   <= fire_a0;
        cmd_arg1   <= fire_a1;
        case (fire_op)
          OP_DISPLAY_OFF: display_on <= 1'b0;
          OP_DISPLAY_ON:  display_on <= 1'b1;
          OP_CONTRAST:    contrast   <= fire_a0;
          OP_ADDR_MODE:   addr_mode  <= fire_a0[1:0];
          OP_NORMAL:      inverse    <= 1'b0;
          OP_INVERSE:     inverse    <= 1'b1;
          OP_COL_ADDR: begin
            col_start <= fire_a0[CW-1:0];
            col_end   <= fire_a1[CW-1:0];
            col       <= fire_a0[CW-1:0];
          end
          OP_PAGE_ADDR: begin
            page_start <= fire_a0[PW-1:0];
            page_end   <= fire_a1[PW-1:0];
            page       <= fire_a0[PW-1:0];
          end
          default: if (is_page_select(fire_op)) page <= fire_op[PW-1:0];
        endcase
      end
      if (wr) begin
        ram_addr  <= 10'(page) * 10'(NUM_COLS) + 10'(col);
        ram_wdata <= rx_byte;
        case (addr_mode)
          AM_HORIZ: begin
            if (col == col_end) begin
              col <= col_start;
              if (page == page_end) begin
                page       <= page_start;
                frame_done <= 1'b1;
              end else begin
                page <= page + PW'(1);
              end
            end else begin
              col <= col + CW'(1);
            end
          end
          AM_VERT: begin
            if (page == page_end) begin
              page <= page_start;
              if (col == col_end) begin
                col        <= col_start;
                frame_done <= 1'b1;
              end else begin
                col <= col + CW'(1);
              end
            end else begin
              page <= page + PW'(1);
            end
          end
          default: col <= (col == col_end) ? col_start : col + CW'(1);
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ssd1306_spi_sink.sv
// tb/tb_ssd1306_spi_sink.sv - directed bench for ssd1306_spi_sink
module tb_ssd1306_spi_sink;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       io_sclk = 1'b1, io_sdin = 1'b0, io_cs = 1'b1, io_dc = 1'b0, io_reset = 1'b1;
  logic       cmd_valid, cmd_err, ram_we, frame_done, display_on, inverse;
  logic [7:0] cmd_opcode, cmd_arg0, cmd_arg1, ram_wdata, contrast;
  logic [9:0] ram_addr;
  logic [1:0] addr_mode;

  int total = 0;
  int bad   = 0;
  int n_cmd, n_err, n_we, n_fd, fd_at;
  logic [7:0] last_wdata;
  logic [9:0] addr_log [0:1099];

  ssd1306_spi_sink dut (
    .clk(clk), .rst(rst),
    .io_sclk(io_sclk), .io_sdin(io_sdin), .io_cs(io_cs), .io_dc(io_dc), .io_reset(io_reset),
    .cmd_valid(cmd_valid), .cmd_opcode(cmd_opcode), .cmd_arg0(cmd_arg0), .cmd_arg1(cmd_arg1),
    .cmd_err(cmd_err), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .frame_done(frame_done), .display_on(display_on), .contrast(contrast),
    .inverse(inverse), .addr_mode(addr_mode)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid) n_cmd++;
      if (cmd_err) n_err++;
      if (frame_done) n_fd++;
      if (ram_we) begin
        if (n_we < 1100) addr_log[n_we] = ram_addr;
        if (frame_done) fd_at = n_we;
        last_wdata = ram_wdata;
        n_we++;
      end
    end
  end

  task automatic clear_mon();
    n_cmd = 0; n_err = 0; n_we = 0; n_fd = 0; fd_at = -1; last_wdata = 8'h00;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input logic d, input int n);
    logic [7:0] v;
    v = b;
    io_cs = 1'b0;
    io_dc = d;
    repeat (2) @(posedge clk);
    for (int i = 0; i < n; i++) begin
      io_sclk = 1'b0;
      io_sdin = v[7-i];
      repeat (3) @(posedge clk);
      io_sclk = 1'b1;
      repeat (3) @(posedge clk);
    end
    io_cs = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic cmd(input logic [7:0] b);
    send_bits(b, 1'b0, 8);
  endtask

  task automatic dat(input logic [7:0] b);
    send_bits(b, 1'b1, 8);
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
  endtask

  int mism;

  initial begin
    clear_mon();
    repeat (4) @(posedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_display_on", display_on, 0);
    check("rst_contrast", contrast, 8'h7F);
    check("rst_addr_mode", addr_mode, 2'b10);
    check("rst_inverse", inverse, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_opcode", cmd_opcode, 0);

    // driver init sequence
    clear_mon();
    cmd(8'hAE); cmd(8'h81); cmd(8'h7F); cmd(8'hA6); cmd(8'h20); cmd(8'h00);
    cmd(8'hD5); cmd(8'h80); cmd(8'hA8); cmd(8'h3F); cmd(8'hD3); cmd(8'h00);
    cmd(8'h40); cmd(8'hC8); cmd(8'hD9); cmd(8'hF1); cmd(8'hDB); cmd(8'h40);
    cmd(8'h8D); cmd(8'h14); cmd(8'hA4); cmd(8'hAF);
    settle();
    check("init_cmd_count", n_cmd, 14);
    check("init_err_count", n_err, 0);
    check("init_contrast", contrast, 8'h7F);
    check("init_addr_mode", addr_mode, 2'b00);
    check("init_display_on", display_on, 1);
    check("init_last_opcode", cmd_opcode, 8'hAF);

    // full-frame horizontal fill
    clear_mon();
    for (int i = 0; i < 1024; i++) dat(8'hAA);
    settle();
    mism = 0;
    for (int i = 0; i < 1024; i++) if (addr_log[i] !== 10'(i)) mism++;
    check("horiz_we_count", n_we, 1024);
    check("horiz_addr_order_mismatches", mism, 0);
    check("horiz_frame_done_count", n_fd, 1);
    check("horiz_frame_done_at", fd_at, 1023);
    check("horiz_wdata", last_wdata, 8'hAA);
    dat(8'h3C);
    settle();
    check("horiz_wrap_addr", addr_log[1024], 10'h000);

    // column/page window
    cmd(8'h21); cmd(8'h10); cmd(8'h1F);
    cmd(8'h22); cmd(8'h02); cmd(8'h03);
    settle();
    clear_mon();
    for (int i = 0; i < 34; i++) dat(8'(i));
    settle();
    check("win_we_count", n_we, 34);
    check("win_addr0", addr_log[0], 10'h110);
    check("win_addr15", addr_log[15], 10'h11F);
    check("win_addr16", addr_log[16], 10'h190);
    check("win_addr31", addr_log[31], 10'h19F);
    check("win_addr32", addr_log[32], 10'h110);
    check("win_addr33", addr_log[33], 10'h111);
    check("win_frame_done_count", n_fd, 1);
    check("win_frame_done_at", fd_at, 31);
    check("win_last_wdata", last_wdata, 8'h21);

    // command truncated by data byte
    clear_mon();
    cmd(8'h81);
    dat(8'h55);
    settle();
    check("trunc_err_count", n_err, 1);
    check("trunc_cmd_count", n_cmd, 0);
    check("trunc_contrast", contrast, 8'h7F);
    check("trunc_we_count", n_we, 1);
    check("trunc_wdata", last_wdata, 8'h55);
    check("trunc_addr", addr_log[0], 10'h112);

    // partial byte discarded on CS high
    cmd(8'hAE);
    cmd(8'hA7);
    settle();
    check("inverse_set", inverse, 1);
    check("display_off", display_on, 0);
    clear_mon();
    send_bits(8'hF8, 1'b0, 5);
    cmd(8'hAF);
    settle();
    check("abort_cmd_count", n_cmd, 1);
    check("abort_opcode", cmd_opcode, 8'hAF);
    check("abort_display_on", display_on, 1);

    // panel soft reset
    cmd(8'h81); cmd(8'h20); cmd(8'hB3);
    settle();
    check("pre_reset_contrast", contrast, 8'h20);
    io_reset = 1'b0;
    repeat (4) @(posedge clk);
    io_reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("soft_rst_contrast", contrast, 8'h7F);
    check("soft_rst_ram_addr", ram_addr, 0);
    check("soft_rst_addr_mode", addr_mode, 2'b10);
    check("soft_rst_display_on", display_on, 0);
    check("soft_rst_inverse", inverse, 0);
    clear_mon();
    dat(8'h99);
    settle();
    check("soft_rst_first_addr", addr_log[0], 10'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
